// File: rtl/triangle_fetch_unit.sv
// Walks the vertex ROM from a base address, groups three consecutive vertices into a triangle
// and presents it on a valid/ready handshake, stopping at the end-of-list sentinel.
module triangle_fetch_unit #(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] SENTINEL = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              sreset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [95:0]       mem_q,
    output logic              tri_valid,
    input  logic              tri_ready,
    output logic [95:0]       tri_p1,
    output logic [95:0]       tri_p2,
    output logic [95:0]       tri_p3,
    output logic [ADDR_W-1:0] tri_index,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCap1,
        StCap2,
        StCap3,
        StPresent
    } state_e;

    localparam logic [ADDR_W-1:0] AddrMax = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [95:0]       v1_q, v1_d, v2_q, v2_d;
    logic [95:0]       p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              is_sentinel;

    assign is_sentinel = (mem_q[95:64] == SENTINEL);

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        index_d    = index_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        p3_d       = p3_q;
        done_d     = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StAddr;
                    mem_addr_d = base_addr;
                    index_d    = '0;
                    err_d      = 1'b0;
                end
            end
            StAddr: begin
                state_d = StCap1;
                // At the top of the ROM the address is held; CAP1 then reports the overflow.
                if (mem_addr_q != AddrMax) begin
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            StCap1: begin
                if (is_sentinel) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (mem_addr_q == AddrMax) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d    = StCap2;
                    v1_d       = mem_q;
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            StCap2: begin
                if (is_sentinel) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = StCap3;
                    v2_d    = mem_q;
                end
            end
            StCap3: begin
                if (is_sentinel) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    // Outputs load all at once so a discarded partial triangle never shows.
                    state_d = StPresent;
                    p1_d    = v1_q;
                    p2_d    = v2_q;
                    p3_d    = mem_q;
                end
            end
            StPresent: begin
                if (tri_ready) begin
                    if (index_q != AddrMax) begin
                        index_d = index_q + 1'b1;
                    end
                    if (mem_addr_q == AddrMax) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = StAddr;
                        mem_addr_d = mem_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q    <= StIdle;
            mem_addr_q <= '0;
            index_q    <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            p3_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            index_q    <= index_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            p3_q       <= p3_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign tri_valid = (state_q == StPresent);
    assign tri_p1    = p1_q;
    assign tri_p2    = p2_q;
    assign tri_p3    = p3_q;
    assign tri_index = index_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_triangle_fetch_unit.sv
// Scoreboarded bench for triangle_fetch_unit: directed lists in a behavioural 1-cycle ROM,
// expected triangles/done results queued by stimulus and checked by a monitor process.
module tb_triangle_fetch_unit;

    localparam int unsigned ADDR_W = 12;

    logic              clk = 1'b0;
    logic              sreset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [95:0]       mem_q;
    logic              tri_valid;
    logic              tri_ready;
    logic [95:0]       tri_p1, tri_p2, tri_p3;
    logic [ADDR_W-1:0] tri_index;
    logic              busy, done, err;

    typedef struct {
        logic [95:0]       p1;
        logic [95:0]       p2;
        logic [95:0]       p3;
        logic [ADDR_W-1:0] idx;
    } tri_t;

    tri_t exp_tri_q[$];
    logic exp_err_q[$];

    logic [95:0] rom [0:4095];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_q <= rom[mem_addr];

    triangle_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .SENTINEL(32'hFFFFFFFF)
    ) dut (
        .clk      (clk),
        .sreset   (sreset),
        .start    (start),
        .base_addr(base_addr),
        .mem_addr (mem_addr),
        .mem_q    (mem_q),
        .tri_valid(tri_valid),
        .tri_ready(tri_ready),
        .tri_p1   (tri_p1),
        .tri_p2   (tri_p2),
        .tri_p3   (tri_p3),
        .tri_index(tri_index),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    function automatic logic [95:0] vert(input int i);
        logic [31:0] x, y, z;
        x = 32'h1000_0000 + 32'(i);
        y = 32'h2000_0000 + 32'(i);
        z = 32'h3000_0000 + 32'(i);
        return {x, y, z};
    endfunction

    function automatic tri_t mk_tri(input int a, input int idx);
        tri_t t;
        t.p1  = vert(a);
        t.p2  = vert(a + 1);
        t.p3  = vert(a + 2);
        t.idx = ADDR_W'(idx);
        return t;
    endfunction

    // Monitor: every accepted triangle and every done pulse is matched against the queues.
    initial begin
        tri_t t;
        logic e;
        forever begin
            @(negedge clk);
            if (!sreset) begin
                if (tri_valid && tri_ready) begin
                    if (exp_tri_q.size() == 0) begin
                        check("unexpected_tri", 1'b1, 1'b0);
                    end else begin
                        t = exp_tri_q.pop_front();
                        check("tri_p1", tri_p1, t.p1);
                        check("tri_p2", tri_p2, t.p2);
                        check("tri_p3", tri_p3, t.p3);
                        check("tri_index", 96'(tri_index), 96'(t.idx));
                    end
                end
                if (done) begin
                    if (exp_err_q.size() == 0) begin
                        check("unexpected_done", 1'b1, 1'b0);
                    end else begin
                        e = exp_err_q.pop_front();
                        check("done_err", 96'(err), 96'(e));
                        check("done_busy", 96'(busy), 96'd0);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // Returns with the bench at T+1 (+1ns), T being the cycle in which start is sampled.
    task automatic start_walk(input int a);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = ADDR_W'(a);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle_gap();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = vert(i);
        rom[6][95:64]  = 32'hFFFFFFFF;
        rom[17][95:64] = 32'hFFFFFFFF;
        rom[32][95:64] = 32'hFFFFFFFF;

        sreset    = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        tri_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_addr", 96'(mem_addr), 96'd0);
        check("rst_valid", 96'(tri_valid), 96'd0);
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_done_err", 96'({done, err}), 96'd0);
        check("rst_index", 96'(tri_index), 96'd0);
        check("rst_p1", tri_p1, 96'd0);
        @(posedge clk);
        #1;
        sreset = 1'b0;

        // Two triangles then the sentinel, consumer always ready.
        exp_tri_q.push_back(mk_tri(0, 0));
        exp_tri_q.push_back(mk_tri(3, 1));
        exp_err_q.push_back(1'b0);
        start_walk(0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("t1_busy", 96'(busy), 96'd1);
                check("t1_addr_t1", 96'(mem_addr), 96'd0);
            end
            if (c == 2) check("t1_addr_t2", 96'(mem_addr), 96'd1);
            if (c == 3) check("t1_addr_t3", 96'(mem_addr), 96'd2);
            check($sformatf("t1_valid_t%0d", c), 96'(tri_valid), 96'(c == 5));
        end
        @(negedge clk);
        check("t1_accept_valid", 96'(tri_valid), 96'd0);
        check("t1_accept_addr", 96'(mem_addr), 96'd3);
        check("t1_accept_index", 96'(tri_index), 96'd1);
        wait_done(40);
        idle_gap();

        // Same list with the consumer stalled for ten cycles on the first triangle.
        tri_ready = 1'b0;
        exp_tri_q.push_back(mk_tri(0, 0));
        exp_tri_q.push_back(mk_tri(3, 1));
        exp_err_q.push_back(1'b0);
        start_walk(0);
        repeat (5) @(negedge clk);
        check("t2_valid_t5", 96'(tri_valid), 96'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t2_hold_valid", 96'(tri_valid), 96'd1);
            check("t2_hold_addr", 96'(mem_addr), 96'd2);
            check("t2_hold_p1", tri_p1, vert(0));
            check("t2_hold_p3", tri_p3, vert(2));
        end
        @(posedge clk);
        #1;
        tri_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t2_resume_valid", 96'(tri_valid), 96'd0);
        check("t2_resume_index", 96'(tri_index), 96'd1);
        check("t2_resume_addr", 96'(mem_addr), 96'd3);
        wait_done(40);
        idle_gap();

        // Sentinel on the second vertex: malformed list.
        exp_err_q.push_back(1'b1);
        start_walk(16);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("t3_done_t%0d", c), 96'(done), 96'(c == 4));
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t3_err_held", 96'(err), 96'd1);
        end
        idle_gap();

        // Walk running into the top of the ROM must stop, never wrapping to 0.
        exp_err_q.push_back(1'b1);
        start_walk(4094);
        @(negedge clk);
        check("t4_err_cleared", 96'(err), 96'd0);
        check("t4_addr_t1", 96'(mem_addr), 96'd4094);
        @(negedge clk);
        check("t4_addr_t2", 96'(mem_addr), 96'd4095);
        @(negedge clk);
        check("t4_done_t3", 96'(done), 96'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_addr_nowrap", 96'(mem_addr), 96'd4095);
        end
        idle_gap();

        // Sentinel on the first vertex: empty list, normal end.
        exp_err_q.push_back(1'b0);
        start_walk(32);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("t5_done_t%0d", c), 96'(done), 96'(c == 3));
        end
        idle_gap();

        // Start while busy is ignored; reset mid-walk clears everything with no done.
        start_walk(40);
        @(negedge clk);
        check("t6_busy", 96'(busy), 96'd1);
        check("t6_addr_t1", 96'(mem_addr), 96'd40);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 12'd48;
        @(negedge clk);
        check("t6_addr_t2", 96'(mem_addr), 96'd41);
        @(posedge clk);
        #1;
        start  = 1'b0;
        sreset = 1'b1;
        @(negedge clk);
        check("t6_addr_t3", 96'(mem_addr), 96'd42);
        @(posedge clk);
        #1;
        sreset = 1'b0;
        @(negedge clk);
        check("t6_rst_addr", 96'(mem_addr), 96'd0);
        check("t6_rst_flags", 96'({tri_valid, busy, done, err}), 96'd0);
        check("t6_rst_index", 96'(tri_index), 96'd0);
        check("t6_rst_p3", tri_p3, 96'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t6_stays_idle", 96'({tri_valid, busy, done}), 96'd0);
        end

        check("tri_queue_empty", 96'(exp_tri_q.size()), 96'd0);
        check("done_queue_empty", 96'(exp_err_q.size()), 96'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
